// File: rtl/vga_rect_fill_pkg.sv
// Shared screen defaults, coordinate widths and FSM encoding for the rectangle filler.
package vga_rect_fill_pkg;

    localparam int XRES_DEF = 640;
    localparam int YRES_DEF = 480;

    localparam int XW  = 10;
    localparam int YW  = 9;
    // One extra bit so that origin + size can never wrap.
    localparam int XEW = XW + 1;
    localparam int YEW = YW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [XEW-1:0] x;
        logic [YEW-1:0] y;
    } xy_t;

endpackage

// File: rtl/vga_rect_fill_xy_scan_counter.sv
// Row-major scan counter: loads a region, then steps one position per enabled cycle.
module xy_scan_counter
    import vga_rect_fill_pkg::*;
(
    input  logic           clk,
    input  logic           srst,
    input  logic           load,
    input  logic           enable,
    input  xy_t            origin,
    input  xy_t            extent,
    output logic [XEW-1:0] cx,
    output logic [YEW-1:0] cy,
    output logic           last
);

    logic [XEW-1:0] ox_q;
    logic [XEW-1:0] ex_q;
    logic [YEW-1:0] ey_q;
    logic [XEW-1:0] cx_q;
    logic [YEW-1:0] cy_q;

    // End coordinates are inclusive; a zero extent is never scanned.
    always_ff @(posedge clk) begin
        if (srst) begin
            ox_q <= '0;
            ex_q <= '0;
            ey_q <= '0;
            cx_q <= '0;
            cy_q <= '0;
        end else if (load) begin
            ox_q <= origin.x;
            ex_q <= origin.x + extent.x - XEW'(1);
            ey_q <= origin.y + extent.y - YEW'(1);
            cx_q <= origin.x;
            cy_q <= origin.y;
        end else if (enable) begin
            if (cx_q == ex_q) begin
                cx_q <= ox_q;
                cy_q <= cy_q + YEW'(1);
            end else begin
                cx_q <= cx_q + XEW'(1);
            end
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign last = (cx_q == ex_q) && (cy_q == ey_q);

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle / full-screen filler emitting one registered pixel write per scan cycle.
module vga_rect_fill
    import vga_rect_fill_pkg::*;
#(
    parameter int XRES    = XRES_DEF,
    parameter int YRES    = YRES_DEF,
    parameter int COLOR_W = 24
) (
    input  logic               CLOCK_50,
    input  logic               Reset,
    input  logic               start,
    input  logic               clear,
    input  logic [XW-1:0]      x0,
    input  logic [YW-1:0]      y0,
    input  logic [XW-1:0]      w,
    input  logic [YW-1:0]      h,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic [XW-1:0]      VGA_X,
    output logic [YW-1:0]      VGA_Y,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot
);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [COLOR_W-1:0] color_q;
    logic [XW-1:0]      vga_x_q;
    logic [YW-1:0]      vga_y_q;
    logic [COLOR_W-1:0] vga_color_q;
    logic               plot_q;
    logic               done_q;

    xy_t            org_d;
    xy_t            ext_d;
    logic           accept;
    logic           in_screen;
    logic [XEW-1:0] cx;
    logic [YEW-1:0] cy;
    logic           last;

    assign accept = (state_q == ST_IDLE) && start;

    always_comb begin
        org_d = '{x: XEW'(x0), y: YEW'(y0)};
        ext_d = '{x: XEW'(w), y: YEW'(h)};
        if (clear) begin
            org_d = '0;
            ext_d = '{x: XEW'(XRES), y: YEW'(YRES)};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ((ext_d.x == '0) || (ext_d.y == '0)) ? ST_DONE : ST_DRAW;
            end
            ST_DRAW: if (last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    xy_scan_counter u_scan (
        .clk    (CLOCK_50),
        .srst   (Reset),
        .load   (accept),
        .enable (state_q == ST_DRAW),
        .origin (org_d),
        .extent (ext_d),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    assign in_screen = (cx < XEW'(XRES)) && (cy < YEW'(YRES));

    // Outputs lag the scan position by one edge; done follows the DONE state likewise.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            color_q     <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            plot_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            plot_q  <= 1'b0;
            done_q  <= (state_q == ST_DONE);
            if (accept) color_q <= color;
            if (state_q == ST_DRAW) begin
                vga_x_q     <= cx[XW-1:0];
                vga_y_q     <= cy[YW-1:0];
                vga_color_q <= color_q;
                plot_q      <= in_screen;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign VGA_X     = vga_x_q;
    assign VGA_Y     = vga_y_q;
    assign VGA_COLOR = vga_color_q;
    assign plot      = plot_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: full-size instance plus a small instance for the clear sweep.
module tb_vga_rect_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, s_start, clr;
    logic [9:0]  x0, w;
    logic [8:0]  y0, h;
    logic [23:0] col;

    logic        busy, done, plot;
    logic [9:0]  vx;
    logic [8:0]  vy;
    logic [23:0] vcol;

    logic        s_busy, s_done, s_plot;
    logic [9:0]  s_vx;
    logic [8:0]  s_vy;
    logic [23:0] s_vcol;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    vga_rect_fill dut (
        .CLOCK_50(clk), .Reset(rst), .start(start), .clear(clr),
        .x0(x0), .y0(y0), .w(w), .h(h), .color(col),
        .busy(busy), .done(done), .VGA_X(vx), .VGA_Y(vy),
        .VGA_COLOR(vcol), .plot(plot)
    );

    vga_rect_fill #(.XRES(20), .YRES(15), .COLOR_W(24)) dut_s (
        .CLOCK_50(clk), .Reset(rst), .start(s_start), .clear(clr),
        .x0(x0), .y0(y0), .w(w), .h(h), .color(col),
        .busy(s_busy), .done(s_done), .VGA_X(s_vx), .VGA_Y(s_vy),
        .VGA_COLOR(s_vcol), .plot(s_plot)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [9:0] ix, input logic [8:0] iy, input logic [9:0] iw,
                         input logic [8:0] ih, input logic [23:0] ic, input logic icl);
        x0 = ix; y0 = iy; w = iw; h = ih; col = ic; clr = icl;
        start = 1'b1;
        tick();
        start = 1'b0;
        clr   = 1'b0;
    endtask

    int bx[6] = '{10, 11, 12, 10, 11, 12};
    int by[6] = '{20, 20, 20, 21, 21, 21};
    int cx[8] = '{638, 639, 640, 641, 638, 639, 640, 641};
    int cp[8] = '{1, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        int n_plot, fx, fy, lx, ly;
        bit seen_done, first;

        rst = 1'b1; start = 1'b0; s_start = 1'b0; clr = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; col = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_x", 32'(vx), 0);
        chk("rst_y", 32'(vy), 0);
        chk("rst_col", 32'(vcol), 0);
        rst = 1'b0;
        tick();
        $display("txn reset: busy=%0d plot=%0d", busy, plot);

        // Basic 3x2 fill
        issue(10'd10, 9'd20, 10'd3, 9'd2, 24'hFF0000, 1'b0);
        chk("basic_busy_k", 32'(busy), 1);
        chk("basic_plot_k", 32'(plot), 0);
        for (int n = 0; n < 6; n++) begin
            tick();
            chk($sformatf("basic_plot%0d", n), 32'(plot), 1);
            chk($sformatf("basic_x%0d", n), 32'(vx), bx[n]);
            chk($sformatf("basic_y%0d", n), 32'(vy), by[n]);
            chk($sformatf("basic_col%0d", n), 32'(vcol), 32'hFF0000);
            chk($sformatf("basic_busy%0d", n), 32'(busy), 1);
            chk($sformatf("basic_done%0d", n), 32'(done), 0);
        end
        tick();
        chk("basic_done", 32'(done), 1);
        chk("basic_plot_end", 32'(plot), 0);
        chk("basic_x_hold", 32'(vx), 12);
        tick();
        chk("basic_done_pulse", 32'(done), 0);
        $display("txn basic: (10,20) 3x2 FF0000");

        // Zero width
        issue(10'd0, 9'd0, 10'd0, 9'd5, 24'h00FF00, 1'b0);
        chk("zero_plot_k", 32'(plot), 0);
        tick();
        chk("zero_done", 32'(done), 1);
        chk("zero_plot", 32'(plot), 0);
        tick();
        chk("zero_done_pulse", 32'(done), 0);
        chk("zero_busy", 32'(busy), 0);
        $display("txn zero: w=0 h=5");

        // Clipping at the bottom-right corner
        issue(10'd638, 9'd479, 10'd4, 9'd2, 24'h0000FF, 1'b0);
        for (int n = 0; n < 8; n++) begin
            tick();
            chk($sformatf("clip_plot%0d", n), 32'(plot), 32'(cp[n]));
            chk($sformatf("clip_done%0d", n), 32'(done), 0);
            if (cp[n] == 1) chk($sformatf("clip_x%0d", n), 32'(vx), 32'(cx[n]));
        end
        tick();
        chk("clip_done", 32'(done), 1);
        tick();
        $display("txn clip: (638,479) 4x2");

        // Clear on the 20x15 instance, ignoring region inputs
        x0 = 10'd5; y0 = 9'd5; w = 10'd1; h = 9'd1; col = 24'h123456; clr = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0; clr = 1'b0;
        n_plot = 0; fx = -1; fy = -1; lx = -1; ly = -1; seen_done = 0; first = 1;
        for (int c = 0; c < 400 && !seen_done; c++) begin
            tick();
            if (s_plot) begin
                if (first) begin fx = int'(s_vx); fy = int'(s_vy); first = 0; end
                lx = int'(s_vx); ly = int'(s_vy);
                n_plot++;
            end
            if (s_done) seen_done = 1;
        end
        chk("clear_done_seen", 32'(seen_done), 1);
        chk("clear_count", 32'(n_plot), 300);
        chk("clear_first_x", 32'(fx), 0);
        chk("clear_first_y", 32'(fy), 0);
        chk("clear_last_x", 32'(lx), 19);
        chk("clear_last_y", 32'(ly), 14);
        chk("clear_col", 32'(s_vcol), 32'h123456);
        tick();
        $display("txn clear: 20x15 plots=%0d", n_plot);

        // Start ignored mid-draw, then reset at scan position 3
        issue(10'd100, 9'd50, 10'd4, 9'd3, 24'hAA55AA, 1'b0);
        tick();
        chk("ign_x0", 32'(vx), 100);
        x0 = 10'd0; y0 = 9'd0; w = 10'd1; h = 9'd1; col = 24'h111111;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_x1", 32'(vx), 101);
        chk("ign_col1", 32'(vcol), 32'hAA55AA);
        tick();
        chk("ign_x2", 32'(vx), 102);
        chk("ign_y2", 32'(vy), 50);
        tick();
        chk("ign_x3", 32'(vx), 103);
        chk("ign_plot3", 32'(plot), 1);
        rst = 1'b1;
        tick();
        chk("abort_plot", 32'(plot), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_x", 32'(vx), 0);
        rst = 1'b0;
        tick();
        chk("abort_plot_after", 32'(plot), 0);
        $display("txn abort: reset at scan position 3");

        issue(10'd1, 9'd2, 10'd2, 9'd1, 24'h00FF00, 1'b0);
        tick();
        chk("post_plot0", 32'(plot), 1);
        chk("post_x0", 32'(vx), 1);
        chk("post_y0", 32'(vy), 2);
        tick();
        chk("post_x1", 32'(vx), 2);
        chk("post_col1", 32'(vcol), 32'h00FF00);
        tick();
        chk("post_done", 32'(done), 1);
        chk("post_plot_end", 32'(plot), 0);
        $display("txn post: (1,2) 2x1 00FF00");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
